// File: rtl/ifetch.sv
// ifetch: instruction-fetch requester feeding a 2-entry {pc, instr} buffer to decode
//   i_clk            clock
//   i_rst_n          asynchronous active-low reset
//   i_fetch_en       allow issuing new fetches (IDLE/RUN control)
//   i_redirect_valid single-cycle redirect pulse, flushes buffer and inflight
//   i_redirect_pc    redirect target, low two bits ignored
//   o_imem_addr      fetch address to instruction memory
//   o_imem_enable    memory latches o_imem_addr on this edge
//   i_imem_data      read data, valid the cycle after an enabled issue
//   o_out_valid      buffer head holds a valid instruction
//   i_out_ready      decode accepts the head this cycle
//   o_out_pc         pc of head entry
//   o_out_instr      instruction of head entry
module ifetch #(
   parameter int ADDR_W = 32,
   parameter int INSTR_W = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_fetch_en,
   input  logic               i_redirect_valid,
   input  logic [ADDR_W-1:0]  i_redirect_pc,
   output logic [ADDR_W-1:0]  o_imem_addr,
   output logic               o_imem_enable,
   input  logic [INSTR_W-1:0] i_imem_data,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic [ADDR_W-1:0]  o_out_pc,
   output logic [INSTR_W-1:0] o_out_instr
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc, r_inflight_pc, w_redir_pc;
   logic [ADDR_W-1:0] r_fifo_pc [2];
   logic [INSTR_W-1:0] r_fifo_instr [2];
   logic [1:0] r_count;
   logic [2:0] w_used;
   logic r_inflight, w_pop, w_push, w_go, w_issue, w_wr;
   assign w_redir_pc = i_redirect_pc & ~ADDR_W'(3);
   assign o_out_valid = r_count != 2'd0;
   assign o_out_pc = r_fifo_pc[0];
   assign o_out_instr = r_fifo_instr[0];
   assign w_pop = o_out_valid & i_out_ready;
   // a redirect kills the response currently returning from memory
   assign w_push = r_inflight & ~i_redirect_valid;
   // slot for the incoming entry after this cycle's pop has shifted the head
   assign w_wr = (r_count == 2'd2) | ((r_count == 2'd1) & ~w_pop);
   assign w_used = {1'b0, r_count} + {2'b0, r_inflight};
   always_comb begin
      w_state_nxt = i_fetch_en ? RUN : IDLE;
      w_go = (r_state == RUN) & i_fetch_en;
      // credit rule: buffered + inflight - popped must leave a free slot;
      // a redirect flushes everything, so it always has room
      w_issue = w_go & (i_redirect_valid | (w_used < 3'd2 + {2'b0, w_pop}));
      o_imem_enable = w_issue;
      o_imem_addr = (w_go & i_redirect_valid) ? w_redir_pc : r_pc;
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else r_state <= w_state_nxt;
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pc <= RESET_PC;
         r_inflight <= 1'b0;
         r_inflight_pc <= '0;
         r_count <= 2'd0;
         r_fifo_pc[0] <= '0;
         r_fifo_pc[1] <= '0;
         r_fifo_instr[0] <= '0;
         r_fifo_instr[1] <= '0;
      end else begin
         if (i_redirect_valid) r_pc <= w_go ? w_redir_pc + ADDR_W'(4) : w_redir_pc;
         else if (w_issue) r_pc <= r_pc + ADDR_W'(4);
         r_inflight <= w_issue;
         if (w_issue) r_inflight_pc <= o_imem_addr;
         if (w_pop) begin
            r_fifo_pc[0] <= r_fifo_pc[1];
            r_fifo_instr[0] <= r_fifo_instr[1];
         end
         if (w_push) begin
            r_fifo_pc[w_wr] <= r_inflight_pc;
            r_fifo_instr[w_wr] <= i_imem_data;
         end
         r_count <= i_redirect_valid ? 2'd0 : r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end
endmodule
